// File: rtl/wb_bus_decoder.sv
// Single-master Wishbone address decoder with a registered response buffer.
// Routes each request to one of two slaves and completes unmapped or stalled accesses with an error word.
module wb_bus_decoder #(
    parameter logic [31:0] S0_BASE  = 32'h0000_0000,
    parameter logic [31:0] S0_MASK  = 32'hFFFE_0000,
    parameter logic [31:0] S1_BASE  = 32'h0000_0000,
    parameter logic [31:0] S1_MASK  = 32'hC000_0000,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] wbm_adr_i,
    input  logic [31:0] wbm_dat_i,
    input  logic [3:0]  wbm_sel_i,
    input  logic        wbm_we_i,
    input  logic        wbm_cyc_i,
    input  logic        wbm_stb_i,
    output logic [31:0] wbm_dat_o,
    output logic        wbm_ack_o,
    output logic [31:0] wbs0_adr_o,
    output logic [31:0] wbs0_dat_o,
    output logic [3:0]  wbs0_sel_o,
    output logic        wbs0_we_o,
    output logic        wbs0_cyc_o,
    output logic        wbs0_stb_o,
    input  logic [31:0] wbs0_dat_i,
    input  logic        wbs0_ack_i,
    output logic [31:0] wbs1_adr_o,
    output logic [31:0] wbs1_dat_o,
    output logic [3:0]  wbs1_sel_o,
    output logic        wbs1_we_o,
    output logic        wbs1_cyc_o,
    output logic        wbs1_stb_o,
    input  logic [31:0] wbs1_dat_i,
    input  logic        wbs1_ack_i,
    output logic        bus_err_o,
    output logic [31:0] err_adr_o,
    output logic [7:0]  err_cnt_o
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned ADR_W = 32;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned ECNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic [CNT_W-1:0]    r_cnt,     w_cnt_nxt;
    logic [ADR_W-1:0]    r_adr,     w_adr_nxt;
    logic [ADR_W-1:0]    r_dat,     w_dat_nxt;
    logic [SEL_W-1:0]    r_sel,     w_sel_nxt;
    logic                r_we,      w_we_nxt;
    logic                r_stb0,    w_stb0_nxt;
    logic                r_stb1,    w_stb1_nxt;
    logic                r_unmap,   w_unmap_nxt;
    logic [ADR_W-1:0]    r_rdata,   w_rdata_nxt;
    logic                r_ack,     w_ack_nxt;
    logic                r_bus_err, w_bus_err_nxt;
    logic [ADR_W-1:0]    r_err_adr, w_err_adr_nxt;
    logic [ECNT_W-1:0]   r_err_cnt, w_err_cnt_nxt;
    logic                r_block,   w_block_nxt;

    logic                w_req;
    logic                w_hit0;
    logic                w_hit1;
    logic                w_ack_sel;
    logic [ADR_W-1:0]    w_ack_dat;
    logic                w_tmo;

    assign w_req     = wbm_cyc_i & wbm_stb_i;
    assign w_hit0    = (wbm_adr_i & S0_MASK) == S0_BASE;
    assign w_hit1    = ((wbm_adr_i & S1_MASK) == S1_BASE) & ~w_hit0;
    assign w_ack_sel = (r_stb0 & wbs0_ack_i) | (r_stb1 & wbs1_ack_i);
    assign w_ack_dat = r_stb0 ? wbs0_dat_i : wbs1_dat_i;
    assign w_tmo     = r_cnt == CNT_W'(TIMEOUT - 1);

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_adr_nxt     = r_adr;
        w_dat_nxt     = r_dat;
        w_sel_nxt     = r_sel;
        w_we_nxt      = r_we;
        w_stb0_nxt    = r_stb0;
        w_stb1_nxt    = r_stb1;
        w_unmap_nxt   = r_unmap;
        w_rdata_nxt   = r_rdata;
        w_ack_nxt     = 1'b0;
        w_bus_err_nxt = 1'b0;
        w_err_adr_nxt = r_err_adr;
        w_err_cnt_nxt = r_err_cnt;
        w_block_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Unmapped requests hold one cycle in WAIT with no strobe so the
                // error ack lands two cycles after the request.
                if (w_req && !r_block) begin
                    w_adr_nxt   = wbm_adr_i;
                    w_dat_nxt   = wbm_dat_i;
                    w_sel_nxt   = wbm_sel_i;
                    w_we_nxt    = wbm_we_i;
                    w_cnt_nxt   = '0;
                    w_stb0_nxt  = w_hit0;
                    w_stb1_nxt  = w_hit1;
                    w_unmap_nxt = ~(w_hit0 | w_hit1);
                    if (!(w_hit0 | w_hit1)) begin
                        w_rdata_nxt = ERR_DATA;
                    end
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!wbm_cyc_i) begin
                    w_stb0_nxt  = 1'b0;
                    w_stb1_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (r_unmap || (!w_ack_sel && w_tmo)) begin
                    w_stb0_nxt    = 1'b0;
                    w_stb1_nxt    = 1'b0;
                    w_rdata_nxt   = ERR_DATA;
                    w_ack_nxt     = 1'b1;
                    w_bus_err_nxt = 1'b1;
                    w_err_adr_nxt = r_adr;
                    if (r_err_cnt != ECNT_W'(255)) begin
                        w_err_cnt_nxt = r_err_cnt + ECNT_W'(1);
                    end
                    w_state_nxt = ST_RESP;
                end else if (w_ack_sel) begin
                    w_stb0_nxt  = 1'b0;
                    w_stb1_nxt  = 1'b0;
                    w_rdata_nxt = w_ack_dat;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_unmap_nxt = 1'b0;
                w_block_nxt = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_stb0_nxt  = 1'b0;
                w_stb1_nxt  = 1'b0;
                w_unmap_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_we      <= 1'b0;
            r_stb0    <= 1'b0;
            r_stb1    <= 1'b0;
            r_unmap   <= 1'b0;
            r_rdata   <= '0;
            r_ack     <= 1'b0;
            r_bus_err <= 1'b0;
            r_err_adr <= '0;
            r_err_cnt <= '0;
            r_block   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_adr     <= w_adr_nxt;
            r_dat     <= w_dat_nxt;
            r_sel     <= w_sel_nxt;
            r_we      <= w_we_nxt;
            r_stb0    <= w_stb0_nxt;
            r_stb1    <= w_stb1_nxt;
            r_unmap   <= w_unmap_nxt;
            r_rdata   <= w_rdata_nxt;
            r_ack     <= w_ack_nxt;
            r_bus_err <= w_bus_err_nxt;
            r_err_adr <= w_err_adr_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_block   <= w_block_nxt;
        end
    end

    assign wbm_dat_o  = r_rdata;
    assign wbm_ack_o  = r_ack;
    assign wbs0_adr_o = r_adr;
    assign wbs0_dat_o = r_dat;
    assign wbs0_sel_o = r_sel;
    assign wbs0_we_o  = r_we;
    assign wbs0_cyc_o = r_stb0;
    assign wbs0_stb_o = r_stb0;
    assign wbs1_adr_o = r_adr;
    assign wbs1_dat_o = r_dat;
    assign wbs1_sel_o = r_sel;
    assign wbs1_we_o  = r_we;
    assign wbs1_cyc_o = r_stb1;
    assign wbs1_stb_o = r_stb1;
    assign bus_err_o  = r_bus_err;
    assign err_adr_o  = r_err_adr;
    assign err_cnt_o  = r_err_cnt;

endmodule
